// File: rtl/adc_sample_sequencer_if.sv
// rtl/adc_sample_sequencer_if.sv - dual-AD7264 SPI connector signal bundle
interface adc_sample_sequencer_if;
    logic        ss;
    logic        load;
    logic [15:0] cmd_out;
    logic        finished;
    logic        loaded;
    logic [13:0] adc_a;
    logic [13:0] adc_b;

    modport master (
        output ss,
        output load,
        output cmd_out,
        input  finished,
        input  loaded,
        input  adc_a,
        input  adc_b
    );

    modport slave (
        input  ss,
        input  load,
        input  cmd_out,
        output finished,
        output loaded,
        output adc_a,
        output adc_b
    );
endinterface

// File: rtl/adc_sample_sequencer.sv
// rtl/adc_sample_sequencer.sv - periodic AD7264 frame sequencer with capture FIFO
module adc_sample_sequencer #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int LOAD_MAX   = 4,
    parameter int QUIET      = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    adc_sample_sequencer_if.master        conn,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          period,
    input  logic [15:0]                   cmd_word,
    input  logic                          rd_en,
    output logic [27:0]                   rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    output logic                          load_err,
    input  logic                          err_clr,
    output logic                          busy
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (LOAD_MAX > QUIET) ? LOAD_MAX : QUIET;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONVERT,
        S_SETTLE,
        S_CAPTURE,
        S_QUIET
    } state_t;

    logic [DIV_WIDTH-1:0] tmr_q, tmr_d;
    logic                 tick;

    state_t               state_q;
    logic                 ss_q, load_q, busy_q, pending_q, load_err_q;
    logic [15:0]          cmd_q;
    logic [CW-1:0]        cnt_q;
    logic                 load_timeout;

    logic [27:0]          mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level_d;
    logic [27:0]          rd_data_q, head_d, push_data;
    logic                 overrun_q;
    logic                 capture, full, pop_ok, push_ok, ovf_set;

    always_comb begin
        tick = enable && (tmr_q == '0);
        if (!enable) begin
            tmr_d = '0;
        end else if (tick) begin
            tmr_d = period;
        end else begin
            tmr_d = tmr_q - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign load_timeout = (state_q == S_LOAD) && !conn.loaded && (cnt_q == CW'(LOAD_MAX - 1));

    // Outputs are registered alongside the state so ss/load change on the same edge as the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ss_q       <= 1'b1;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            cmd_q      <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && (tick || pending_q)) begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cmd_q   <= cmd_word;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (conn.loaded || load_timeout) begin
                        state_q <= S_CONVERT;
                        load_q  <= 1'b0;
                        ss_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_CONVERT: begin
                    if (conn.finished) begin
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state_q <= S_QUIET;
                    ss_q    <= 1'b1;
                    cnt_q   <= '0;
                end
                S_QUIET: begin
                    if (cnt_q == CW'(QUIET - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ss_q    <= 1'b1;
                    load_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            // A tick seen in IDLE is either consumed or irrelevant; only busy-time ticks are remembered.
            if (!enable || state_q == S_IDLE) begin
                pending_q <= 1'b0;
            end else if (tick) begin
                pending_q <= 1'b1;
            end

            load_err_q <= (load_err_q & ~err_clr) | load_timeout;
        end
    end

    assign capture   = (state_q == S_CAPTURE);
    assign push_data = {conn.adc_a, conn.adc_b};
    assign level     = wr_ptr_q - rd_ptr_q;
    assign empty     = (level == '0);
    assign full      = (level == (AW + 1)'(FIFO_DEPTH));
    assign pop_ok    = rd_en && !empty;
    assign push_ok   = capture && (!full || pop_ok);
    assign ovf_set   = capture && full && !pop_ok;

    // The head register must show a word written this cycle when it lands in an empty slot at the head.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop_ok);
        level_d  = wr_ptr_d - rd_ptr_d;
        if (level_d == '0) begin
            head_d = '0;
        end else if (push_ok && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= head_d;
            overrun_q <= (overrun_q & ~err_clr) | ovf_set;
        end
    end

    assign conn.ss      = ss_q;
    assign conn.load    = load_q;
    assign conn.cmd_out = cmd_q;
    assign rd_data      = rd_data_q;
    assign overrun      = overrun_q;
    assign load_err     = load_err_q;
    assign busy         = busy_q;

endmodule
